// File: rtl/nes_host_bridge.sv
// nes_host_bridge: host command decoder and CPU run control for the 6502 core.
// The host drives {opcode, data} plus an address operand. The bridge decides
// whether the CPU or the host owns the memory port. It also holds a breakpoint
// comparator and counts the cycles in which the CPU was enabled.
module nes_host_bridge #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int OP_W   = 8,
  parameter int CYC_W  = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   chipselect,
  input  logic                   write,
  input  logic [OP_W+DATA_W-1:0] writedata,
  input  logic [ADDR_W-1:0]      address,
  output logic [DATA_W-1:0]      readdata,
  output logic                   busy,
  output logic                   cpu_reset,
  output logic                   cpu_ready,
  input  logic [ADDR_W-1:0]      cpu_addr,
  input  logic [DATA_W-1:0]      cpu_dout,
  input  logic                   cpu_write,
  input  logic                   cpu_sync,
  output logic [DATA_W-1:0]      cpu_din,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [DATA_W-1:0]      mem_wdata,
  output logic                   mem_write,
  input  logic [DATA_W-1:0]      mem_rdata,
  output logic [CYC_W-1:0]       cycle_count
);

  typedef enum logic [2:0] {
    S_RST    = 3'd0,
    S_PAUSED = 3'd1,
    S_RUN    = 3'd2,
    S_STEP   = 3'd3,
    S_HWR    = 3'd4,
    S_HRD    = 3'd5
  } state_t;

  localparam logic [OP_W-1:0] OP_RESET_CPU = OP_W'(0);
  localparam logic [OP_W-1:0] OP_START     = OP_W'(1);
  localparam logic [OP_W-1:0] OP_PAUSE     = OP_W'(2);
  localparam logic [OP_W-1:0] OP_WRITE_MEM = OP_W'(3);
  localparam logic [OP_W-1:0] OP_READ_MEM  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_STEP      = OP_W'(5);
  localparam logic [OP_W-1:0] OP_SET_BP    = OP_W'(6);
  localparam logic [OP_W-1:0] OP_CLR_BP    = OP_W'(7);
  localparam logic [OP_W-1:0] OP_STATUS    = OP_W'(8);

  state_t              state_reg;
  state_t              prior_reg;       // state to return to after a host access
  logic [ADDR_W-1:0]   haddr_reg;
  logic [DATA_W-1:0]   hdata_reg;
  logic [ADDR_W-1:0]   bp_addr_reg;
  logic                bp_en_reg;
  logic                err_reg;
  logic                bp_hit_reg;
  logic                bp_skip_reg;     // ignore the breakpoint on the first sync after PAUSED
  logic                step_armed_reg;  // at least one ready cycle has elapsed in STEP
  logic                hrd_second_reg;  // second cycle of a host read

  logic [OP_W-1:0]     opcode;
  logic                accept;
  logic                cpu_owns;
  logic                step_end;
  logic                bp_match;
  logic [DATA_W-1:0]   status_byte;

  assign opcode   = writedata[OP_W+DATA_W-1:DATA_W];
  assign accept   = chipselect && write;
  assign cpu_owns = (state_reg == S_RUN) || (state_reg == S_STEP);
  assign busy     = (state_reg == S_HWR) || (state_reg == S_HRD);
  assign cpu_reset = (state_reg == S_RST);
  assign cpu_din  = mem_rdata;

  // The step ends at the next opcode fetch. Ready is gated in that same cycle,
  // so the CPU parks on the fetch and does not execute it.
  assign step_end  = (state_reg == S_STEP) && step_armed_reg && cpu_sync;
  assign cpu_ready = (state_reg == S_RUN) || ((state_reg == S_STEP) && !step_end);

  // A host command in the same cycle takes priority over the breakpoint.
  assign bp_match = (state_reg == S_RUN) && bp_en_reg && cpu_sync && !bp_skip_reg &&
                    !accept && (cpu_addr == bp_addr_reg);

  // Status byte, zero-extended to the data width.
  always_comb begin
    status_byte      = '0;
    status_byte[7:0] = {bp_hit_reg, err_reg, bp_en_reg, 2'b00, state_reg};
  end

  // Memory port mux: the CPU owns it while running; otherwise the host owns it.
  always_comb begin
    mem_addr  = haddr_reg;
    mem_wdata = hdata_reg;
    mem_write = 1'b0;
    if (cpu_owns) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_dout;
      mem_write = cpu_write;
    end else if (state_reg == S_HWR) begin
      mem_write = 1'b1;
    end
  end

  // Control FSM, command decode, breakpoint and cycle counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= S_RST;
      prior_reg      <= S_RST;
      haddr_reg      <= '0;
      hdata_reg      <= '0;
      bp_addr_reg    <= '0;
      bp_en_reg      <= 1'b0;
      err_reg        <= 1'b0;
      bp_hit_reg     <= 1'b0;
      bp_skip_reg    <= 1'b0;
      step_armed_reg <= 1'b0;
      hrd_second_reg <= 1'b0;
      readdata       <= '0;
      cycle_count    <= '0;
    end else begin
      if (state_reg == S_RST) begin
        cycle_count <= '0;
      end else if (cpu_ready) begin
        cycle_count <= cycle_count + CYC_W'(1);
      end

      if (cpu_ready && cpu_sync) begin
        bp_skip_reg <= 1'b0;
      end
      if ((state_reg == S_STEP) && cpu_ready) begin
        step_armed_reg <= 1'b1;
      end

      // Autonomous progress. A command accepted below overrides these transitions.
      case (state_reg)
        S_HWR: state_reg <= prior_reg;
        S_HRD: begin
          if (hrd_second_reg) begin
            readdata  <= mem_rdata;
            state_reg <= prior_reg;
          end else begin
            hrd_second_reg <= 1'b1;
          end
        end
        S_RUN: begin
          if (bp_match) begin
            state_reg  <= S_PAUSED;
            bp_hit_reg <= 1'b1;
          end
        end
        S_STEP: begin
          if (step_end && !accept) begin
            state_reg <= S_PAUSED;
          end
        end
        default: ;
      endcase

      if (accept) begin
        if (busy) begin
          err_reg <= 1'b1;
        end else begin
          case (opcode)
            OP_RESET_CPU: state_reg <= S_RST;
            OP_START: begin
              state_reg <= S_RUN;
              if (state_reg == S_PAUSED) bp_skip_reg <= 1'b1;
            end
            OP_PAUSE: state_reg <= S_PAUSED;
            OP_STEP: begin
              state_reg      <= S_STEP;
              step_armed_reg <= 1'b0;
              if (state_reg == S_PAUSED) bp_skip_reg <= 1'b1;
            end
            OP_WRITE_MEM: begin
              prior_reg <= state_reg;
              haddr_reg <= address;
              hdata_reg <= writedata[DATA_W-1:0];
              state_reg <= S_HWR;
            end
            OP_READ_MEM: begin
              prior_reg      <= state_reg;
              haddr_reg      <= address;
              hrd_second_reg <= 1'b0;
              state_reg      <= S_HRD;
            end
            OP_SET_BP: begin
              bp_addr_reg <= address;
              bp_en_reg   <= 1'b1;
            end
            OP_CLR_BP: bp_en_reg <= 1'b0;
            OP_STATUS: begin
              readdata   <= status_byte;
              err_reg    <= 1'b0;
              bp_hit_reg <= 1'b0;
            end
            default: err_reg <= 1'b1;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_nes_host_bridge.sv
// Testbench for nes_host_bridge. It uses a 64K memory with registered reads.
// The CPU stand-in is a NOP-only core: a sync fetch at PC, then a dummy read of
// PC+1, then PC advances. Host data is checked against a reference memory map.
// Cycle counts are checked with arithmetic on the number of enabled cycles.
module tb_nes_host_bridge;

  logic        clk, reset, chipselect, write;
  logic [15:0] writedata, address;
  logic [7:0]  readdata;
  logic        busy, cpu_reset, cpu_ready;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic        cpu_write, cpu_sync;
  logic [7:0]  cpu_din;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_write;
  logic [7:0]  mem_rdata;
  logic [31:0] cycle_count;

  int checks = 0;
  int errors = 0;

  nes_host_bridge dut (
    .clk(clk), .reset(reset), .chipselect(chipselect), .write(write),
    .writedata(writedata), .address(address), .readdata(readdata), .busy(busy),
    .cpu_reset(cpu_reset), .cpu_ready(cpu_ready), .cpu_addr(cpu_addr),
    .cpu_dout(cpu_dout), .cpu_write(cpu_write), .cpu_sync(cpu_sync),
    .cpu_din(cpu_din), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_write(mem_write), .mem_rdata(mem_rdata), .cycle_count(cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory with a one-cycle read latency.
  logic [7:0] mem [0:65535];
  always @(posedge clk) begin
    if (mem_write) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  // NOP-only CPU stand-in. It advances only on enabled cycles.
  logic [15:0] pc;
  logic        ph;
  always @(posedge clk) begin
    if (cpu_reset) begin
      pc <= 16'h8000;
      ph <= 1'b0;
    end else if (cpu_ready) begin
      if (ph) pc <= pc + 16'd1;
      ph <= ~ph;
    end
  end
  assign cpu_addr = ph ? pc + 16'd1 : pc;
  assign cpu_sync = ~ph;

  // Address of the last opcode fetch the CPU actually executed, plus a free edge count.
  logic [15:0] last_sync;
  longint      cyc = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cpu_ready && cpu_sync) last_sync <= cpu_addr;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One host command. Call at edge+1; returns at edge+1 of the accepting edge.
  task automatic send(input logic [7:0] op, input logic [15:0] a, input logic [7:0] d);
    chipselect = 1'b1;
    write      = 1'b1;
    writedata  = {op, d};
    address    = a;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write      = 1'b0;
    $display("t=%0t cmd op=0x%02h addr=0x%04h data=0x%02h", $time, op, a, d);
  endtask

  task automatic hwrite(input logic [15:0] a, input logic [7:0] d, output int n);
    send(8'd3, a, d);
    n = 0;
    while (busy && n < 8) begin n++; tick(); end
  endtask

  task automatic hread(input logic [15:0] a, output logic [7:0] d, output int n);
    send(8'd4, a, 8'h00);
    n = 0;
    while (busy && n < 8) begin n++; tick(); end
    d = readdata;
  endtask

  task automatic status(output logic [7:0] s);
    send(8'd8, 16'h0000, 8'h00);
    s = readdata;
  endtask

  // Status byte rule: {bp_hit, err, bp_en, 00, state}; states in listed order RST..HRD = 0..5.
  function automatic logic [7:0] sb(input logic hit, input logic e, input logic en, input logic [2:0] st);
    return {hit, e, en, 2'b00, st};
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  d, s;
    int          n;
    logic [31:0] cc0;
    longint      cyc0;
    logic [15:0] a;
    logic [15:0] addrs [$];
    logic [7:0]  ref_mem [int];

    reset = 1'b1; chipselect = 1'b0; write = 1'b0; writedata = '0; address = '0;
    cpu_dout = '0; cpu_write = 1'b0;
    #2;
    check("rst_cpu_reset", cpu_reset, 1'b1);
    check("rst_cpu_ready", cpu_ready, 1'b0);
    check("rst_mem_write", mem_write, 1'b0);
    check("rst_busy", busy, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    check("rst_readdata", readdata, 8'h00);
    check("rst_cycle_count", cycle_count, 32'd0);
    status(s);
    check("rst_status", s, sb(0, 0, 0, 3'd0));

    // Directed host write then read of 0x8000.
    send(8'd3, 16'h8000, 8'hA9);
    check("hwr_busy", busy, 1'b1);
    check("hwr_mem_write", mem_write, 1'b1);
    check("hwr_mem_addr", mem_addr, 16'h8000);
    check("hwr_mem_wdata", mem_wdata, 8'hA9);
    tick();
    check("hwr_done", busy, 1'b0);
    hread(16'h8000, d, n);
    check("hrd_data", d, 8'hA9);
    check("hrd_busy_cycles", n, 2);

    // Random host writes and readbacks against the reference map.
    for (int i = 0; i < 16; i++) begin
      a = 16'($urandom_range(0, 16'h3FFF));
      d = 8'($urandom);
      hwrite(a, d, n);
      ref_mem[int'(a)] = d;
      addrs.push_back(a);
      check("rnd_wr_busy", n, 1);
    end
    addrs.shuffle();
    foreach (addrs[i]) begin
      hread(addrs[i], d, n);
      check("rnd_rd_data", d, ref_mem[int'(addrs[i])]);
    end

    // Load NOPs into the program area.
    for (int i = 0; i < 32; i++) hwrite(16'h8000 + 16'(i), 8'hEA, n);

    // Single step from PAUSED at 0x8000.
    send(8'd2, 16'h0000, 8'h00);
    check("paused_at", cpu_addr, 16'h8000);
    cc0 = cycle_count;
    check("cc_before_step", cc0, 32'd0);
    send(8'd5, 16'h0000, 8'h00);
    n = 0;
    while (cpu_ready && n < 20) begin n++; tick(); end
    tick();
    check("step_cc", cycle_count - cc0, 32'd2);
    check("step_addr", cpu_addr, 16'h8001);
    status(s);
    check("step_status", s, sb(0, 0, 0, 3'd1));

    // Breakpoint at 0x8003, run from the fetch at 0x8001.
    send(8'd6, 16'h8003, 8'h00);
    cc0 = cycle_count;
    send(8'd1, 16'h0000, 8'h00);
    n = 0;
    while (cpu_ready && n < 50) begin n++; tick(); end
    tick();
    check("bp_sync_addr", last_sync, 16'h8003);
    check("bp_cc", cycle_count - cc0, 32'(2 * (16'h8003 - 16'h8001) + 1));
    status(s);
    check("bp_status", s, sb(1, 0, 1, 3'd1));
    status(s);
    check("bp_status_clr", s, sb(0, 0, 1, 3'd1));

    // Park on a fetch exactly at the breakpoint; START must not stop there again.
    send(8'd5, 16'h0000, 8'h00);
    n = 0;
    while (cpu_ready && n < 20) begin n++; tick(); end
    tick();
    check("park_addr", cpu_addr, 16'h8004);
    send(8'd6, 16'h8004, 8'h00);
    send(8'd1, 16'h0000, 8'h00);
    repeat (10) tick();
    check("resume_ready", cpu_ready, 1'b1);
    status(s);
    check("resume_status", s, sb(0, 0, 1, 3'd2));

    // Host read while running, plus a command that arrives while busy.
    send(8'd4, 16'h8000, 8'h00);
    check("rrun_stall1", cpu_ready, 1'b0);
    send(8'd7, 16'h0000, 8'h00);
    check("rrun_stall2", cpu_ready, 1'b0);
    tick();
    check("rrun_resume", cpu_ready, 1'b1);
    check("rrun_data", readdata, 8'hEA);
    status(s);
    check("busy_cmd_err", s, sb(0, 1, 1, 3'd2));

    // CPU owns the memory port in RUN.
    cpu_dout = 8'($urandom);
    cpu_write = 1'b1;
    #1;
    check("mux_write", mem_write, 1'b1);
    check("mux_addr", mem_addr, cpu_addr);
    check("mux_wdata", mem_wdata, cpu_dout);
    check("mux_din", cpu_din, mem_rdata);
    cpu_write = 1'b0;
    tick();
    cc0 = cycle_count;
    repeat (5) tick();
    check("run_cc_rate", cycle_count - cc0, 32'd5);

    // Undefined opcode leaves the state alone.
    send(8'd2, 16'h0000, 8'h00);
    send(8'hFF, 16'h0000, 8'h00);
    status(s);
    check("bad_op_status", s, sb(0, 1, 1, 3'd1));
    status(s);
    check("bad_op_clr", s, sb(0, 0, 1, 3'd1));

    // Reset in the middle of a host write must not commit the write.
    hwrite(16'h1234, 8'h55, n);
    hread(16'h1234, d, n);
    check("pre_abort_data", d, 8'h55);
    send(8'd3, 16'h1234, 8'h77);
    check("abort_hwr_active", mem_write, 1'b1);
    reset = 1'b1;
    #1;
    check("abort_mem_write", mem_write, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_cpu_reset", cpu_reset, 1'b1);
    @(posedge clk); #1;
    reset = 1'b0;
    hread(16'h1234, d, n);
    check("abort_no_corrupt", d, 8'h55);
    check("abort_cc", cycle_count, 32'd0);
    status(s);
    check("abort_status", s, sb(0, 0, 0, 3'd0));

    // Random host traffic while running. The CPU loses exactly the busy cycles.
    send(8'd1, 16'h0000, 8'h00);
    for (int i = 0; i < 12; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      cc0  = cycle_count;
      cyc0 = cyc;
      a = 16'($urandom_range(0, 16'h3FFF));
      if (($urandom_range(0, 1) == 0) || !ref_mem.exists(int'(a))) begin
        d = 8'($urandom);
        hwrite(a, d, n);
        ref_mem[int'(a)] = d;
        check("run_wr_busy", n, 1);
      end else begin
        hread(a, d, n);
        check("run_rd_data", d, ref_mem[int'(a)]);
        check("run_rd_busy", n, 2);
      end
      check("run_cc_stall", cycle_count - cc0, 32'((cyc - cyc0) - longint'(n)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
